match_controller: RTL
=====================

# match_controller

Top-level game sequencer for the Pong datapath. Owns the match state machine: latches difficulty and wrap mode at match start, and gates `game_on` to the paddle and computer-player blocks. Times the serve delay and issues the serve pulse to the ball block, and counts points from ball-miss pulses up to a win score. Sits between the board buttons/switches and the `compPlayer`, paddle and ball modules.

## Interface
Parameters:
- `SERVE_TICKS`, 50_000_000 — cycles spent in SERVE_WAIT before launch (≥1)
- `PAUSE_TICKS`, 25_000_000 — cycles spent in POINT after a score (≥1)
- `WIN_SCORE`, 7 — points needed to win (1..15)

Ports:
- `clk`  in  1  — system clock; one clock domain
- `reset`  in  1  — synchronous, active-high
- `start_btn`  in  1  — level; rising edge detected internally
- `pause_btn`  in  1  — level; rising edge detected internally
- `diff_sel`  in  2  — difficulty switches; sampled only at match start
- `wrap_sel`  in  1  — wrap-mode switch; sampled only at match start
- `miss_left`  in  1  — 1-cycle pulse: ball passed left paddle (right player scores)
- `miss_right`  in  1  — 1-cycle pulse: ball passed right paddle (left player scores)
- `game_on`  out  1  — high only in PLAY
- `serve`  out  1  — 1-cycle launch pulse to the ball block
- `serve_dir`  out  1  — 0 = toward left, 1 = toward right; valid while `serve` is high
- `diff`  out  2  — latched difficulty, to `compPlayer`
- `wrapping`  out  1  — latched wrap mode
- `score_left`  out  4  — left score
- `score_right`  out  4  — right score
- `winner`  out  2  — 00 none, 01 left, 10 right
- `state_out`  out  3  — state encoding, for debug/display

## Operation
- States and encodings: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, PAUSED=4, GAME_OVER=5. Codes 6 and 7 go to IDLE on the next clock.
- Edge detect: one register each for `start_btn` and `pause_btn`. `start_rise = start_btn & ~start_q`. `pause_rise` is formed the same way.
- IDLE: on `start_rise`:
  - latch `diff` ← `diff_sel` and `wrapping` ← `wrap_sel`;
  - clear both scores and `winner`;
  - set `serve_dir` = 1;
  - go to SERVE_WAIT.
- SERVE_WAIT: the down-counter loads `SERVE_TICKS-1` on entry and decrements each cycle. At 0, go to PLAY.
- PLAY: `serve` is asserted in the first PLAY cycle only.
  - `miss_left` alone: `score_right`+1, go to POINT.
  - `miss_right` alone: `score_left`+1, go to POINT.
  - Both in the same cycle: no score, go to SERVE_WAIT, `serve_dir` unchanged (replay).
  - Misses take priority over `pause_rise` in the same cycle.
  - `pause_rise` with no miss: go to PAUSED.
- PAUSED: `game_on`=0. `pause_rise` returns to PLAY without a new `serve` pulse. Miss pulses are ignored.
- POINT: the counter loads `PAUSE_TICKS-1` on entry.
  - If the incremented score equals `WIN_SCORE`: go to GAME_OVER on the next cycle and set `winner`.
  - Otherwise: at counter 0, go to SERVE_WAIT.
- GAME_OVER: scores and `winner` hold. `start_rise` behaves exactly like the start from IDLE.
- Miss pulses outside PLAY are ignored. Scores saturate at 15 and never wrap.
- The internal counter is `$clog2(max(SERVE_TICKS, PAUSE_TICKS))` bits wide, unsigned.

## Timing
- Reset values:
  - state=IDLE, `game_on`=0, `serve`=0, `serve_dir`=1;
  - `diff`=00, `wrapping`=0;
  - both scores=0, `winner`=00, `state_out`=0;
  - edge registers=0 and counter=0.
- Reset takes effect at any state on the next clock edge and aborts any count in progress.
- All outputs are registered.
- `start_rise` in the sampled cycle puts SERVE_WAIT on the outputs one cycle later.
- SERVE_WAIT occupies exactly `SERVE_TICKS` cycles. The first PLAY cycle shows `game_on`=1 and `serve`=1 together.
- A miss sampled in cycle N produces the score increment and `state_out`=POINT at N+1. `game_on` drops at N+1.
- POINT lasts exactly `PAUSE_TICKS` cycles. In the winning case it lasts exactly 1 cycle.
- A held button generates exactly one event.

## Configuration
- `MATCH_SERVE_ALTERNATE_EN` defined: `serve_dir` toggles after every scored point, regardless of who scored.
- Not defined: the next serve goes toward the player who lost the point. `miss_left` → `serve_dir`=0; `miss_right` → `serve_dir`=1.
- Replays (simultaneous misses) never change `serve_dir` in either build.

## Test plan
Parameters for all scenarios: `SERVE_TICKS`=4, `PAUSE_TICKS`=3, `WIN_SCORE`=2.
- Reset then `start_rise` with `diff_sel`=10, `wrap_sel`=1:
  - `diff`=10, `wrapping`=1, state=1 for 4 cycles;
  - then state=2 with `game_on`=1 and `serve`=1 for one cycle, `serve_dir`=1.
- In PLAY, one `miss_right` pulse: `score_left`=1 next cycle; state=3 for 3 cycles, then state=1.
- `miss_left` and `miss_right` together in PLAY: scores unchanged, state=1, `serve_dir` unchanged.
- Pause: `pause_rise` in PLAY gives state=4 and `game_on`=0. A `miss_left` during PAUSED leaves scores at 0. A second `pause_rise` gives state=2 with `serve`=0.
- Win: two `miss_left` points give `score_right`=2, state=5, `winner`=10, with POINT lasting 1 cycle. A later `start_rise` clears scores and enters state=1.
- Reset asserted mid-SERVE_WAIT and mid-GAME_OVER: all outputs at reset values on the next cycle. Check `serve_dir` in both macro builds after a `miss_left` point: 0 without the macro, toggled with it.

Source files
------------

// File: rtl/match_controller.sv
// match_controller: Pong match sequencer.
// Owns the match FSM (IDLE, SERVE_WAIT, PLAY, POINT, PAUSED, GAME_OVER).
// It latches difficulty and wrap mode at match start, times the serve delay
// and the post-point pause, issues the serve pulse, and keeps score up to
// WIN_SCORE.
// Optional build macro: MATCH_SERVE_ALTERNATE_EN. When it is defined,
// serve_dir toggles after every scored point. Otherwise the next serve goes
// toward the player who lost the point.
// Handshake note: the block has no valid/ready pairs. Miss pulses are
// single-cycle strobes and are only acted on in PLAY. Buttons are levels,
// and each rising edge is one event.
// The FSM state is exposed on state_out for debug and display.
module match_controller #(
  parameter int SERVE_TICKS = 50_000_000,
  parameter int PAUSE_TICKS = 25_000_000,
  parameter int WIN_SCORE   = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [1:0] diff_sel,
  input  logic       wrap_sel,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       game_on,
  output logic       serve,
  output logic       serve_dir,
  output logic [1:0] diff,
  output logic       wrapping,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state_out
);

  localparam int MAX_TICKS = (SERVE_TICKS > PAUSE_TICKS) ? SERVE_TICKS : PAUSE_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0] PAUSE_LOAD = CNT_W'(PAUSE_TICKS - 1);
  localparam logic [3:0]       WIN       = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_PAUSED     = 3'd4,
    ST_GAME_OVER  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, pause_q;
  logic [1:0]       diff_q, diff_d;
  logic             wrap_q, wrap_d;
  logic [3:0]       score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]       winner_q, winner_d;
  logic             serve_q, serve_d;
  logic             game_on_q, game_on_d;
  logic             dir_q, dir_d;
  logic             start_rise, pause_rise;

  assign start_rise = start_btn & ~start_q;
  assign pause_rise = pause_btn & ~pause_q;

  // Scores stop at 15 rather than wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  // State, counter, edge registers and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      diff_q    <= 2'b00;
      wrap_q    <= 1'b0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      winner_q  <= 2'b00;
      serve_q   <= 1'b0;
      game_on_q <= 1'b0;
      dir_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_btn;
      pause_q   <= pause_btn;
      diff_q    <= diff_d;
      wrap_q    <= wrap_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      serve_q   <= serve_d;
      game_on_q <= game_on_d;
      dir_q     <= dir_d;
    end
  end

  // Next-state and next-output logic. Outputs are computed from the next
  // state, so each one is registered and lines up with state_out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    wrap_d    = wrap_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    serve_d   = 1'b0;
    dir_d     = dir_q;
    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_rise) begin
          diff_d    = diff_sel;
          wrap_d    = wrap_sel;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          winner_d  = 2'b00;
          dir_d     = 1'b1;
          cnt_d     = SERVE_LOAD;
          state_d   = ST_SERVE_WAIT;
        end
      end
      ST_SERVE_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_PLAY;
          serve_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PLAY: begin
        if (miss_left && miss_right) begin
          // Both players missed in the same cycle: replay with no score
          // and no change of direction.
          cnt_d   = SERVE_LOAD;
          state_d = ST_SERVE_WAIT;
        end else if (miss_left) begin
          score_r_d = sat_inc(score_r_q);
`ifdef MATCH_SERVE_ALTERNATE_EN
          dir_d     = ~dir_q;
`else
          dir_d     = 1'b0;
`endif
          cnt_d     = PAUSE_LOAD;
          state_d   = ST_POINT;
        end else if (miss_right) begin
          score_l_d = sat_inc(score_l_q);
`ifdef MATCH_SERVE_ALTERNATE_EN
          dir_d     = ~dir_q;
`else
          dir_d     = 1'b1;
`endif
          cnt_d     = PAUSE_LOAD;
          state_d   = ST_POINT;
        end else if (pause_rise) begin
          state_d = ST_PAUSED;
        end
      end
      ST_POINT: begin
        // A winning score ends the match after a single POINT cycle.
        if (score_l_q == WIN) begin
          winner_d = 2'b01;
          state_d  = ST_GAME_OVER;
        end else if (score_r_q == WIN) begin
          winner_d = 2'b10;
          state_d  = ST_GAME_OVER;
        end else if (cnt_q == '0) begin
          cnt_d   = SERVE_LOAD;
          state_d = ST_SERVE_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PAUSED: begin
        if (pause_rise) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
    game_on_d = (state_d == ST_PLAY);
  end

  assign game_on     = game_on_q;
  assign serve       = serve_q;
  assign serve_dir   = dir_q;
  assign diff        = diff_q;
  assign wrapping    = wrap_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign winner      = winner_q;
  assign state_out   = state_q;

endmodule
